// File: rtl/sdram_wb_bridge.sv
// sdram_wb_bridge: kernel 16-bit SDRAM bus to request/ack controller adapter,
// with delayed controller reset, latched transaction fields and PHY byte masks.
module sdram_wb_bridge #(
    parameter int ACK_DLY = 2,
    parameter int RST_DLY = 3
) (
    input  logic        clk_p,
    input  logic        rst_n,
    input  logic        sys_reset,
    input  logic        sdram_stb,
    input  logic        sdram_we,
    input  logic [1:0]  sdram_sel,
    input  logic [21:1] sdram_adr,
    input  logic [15:0] sdram_out,
    output logic [15:0] sdram_dat,
    output logic        sdram_ack,
    output logic        sdram_ready,
    output logic        ctl_rst_n,
    output logic        ctl_wr_req,
    output logic        ctl_rd_req,
    input  logic        ctl_wr_ack,
    input  logic        ctl_rd_ack,
    output logic [21:0] ctl_addr,
    output logic [15:0] ctl_wdata,
    input  logic [15:0] ctl_rdata,
    output logic [1:0]  ctl_be,
    input  logic        ctl_init_done,
    output logic        dm_l,
    output logic        dm_h
);
    localparam int RCW = $clog2(RST_DLY + 1);
    typedef enum logic [1:0] {IDLE, REQ, ACKD, DONE} state_t;
    state_t state, nxt;
    logic sync1, rst_sync, wr_q;
    logic [RCW-1:0] rst_cnt;
    logic [1:0] dly_cnt;
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            rst_sync  <= 1'b0;
            rst_cnt   <= '0;
            ctl_rst_n <= 1'b0;
        end else begin
            sync1    <= sys_reset;
            rst_sync <= sync1;
            if (rst_sync) begin
                rst_cnt   <= '0;
                ctl_rst_n <= 1'b0;
            end else if (!ctl_rst_n) begin
                ctl_rst_n <= rst_cnt == RCW'(RST_DLY - 1);
                rst_cnt   <= rst_cnt + 1'b1;
            end
        end
    end
    assign sdram_ready = ctl_init_done & ctl_rst_n;
    // With ACK_DLY of 1 the wait state has zero length, so REQ jumps straight to DONE
    always_comb begin
        nxt = state;
        if (rst_sync)
            nxt = IDLE;
        else
            case (state)
                IDLE:    nxt = (sdram_stb && sdram_ready) ? REQ : IDLE;
                REQ:     nxt = (wr_q ? ctl_wr_ack : ctl_rd_ack) ? (ACK_DLY == 1 ? DONE : ACKD) : REQ;
                ACKD:    nxt = (dly_cnt == 2'(ACK_DLY - 2)) ? DONE : ACKD;
                default: nxt = sdram_stb ? DONE : IDLE;
            endcase
    end
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dly_cnt   <= 2'd0;
            wr_q      <= 1'b0;
            ctl_addr  <= '0;
            ctl_wdata <= '0;
            ctl_be    <= '0;
            dm_l      <= 1'b0;
            dm_h      <= 1'b0;
            sdram_dat <= '0;
        end else begin
            state   <= nxt;
            dly_cnt <= (state == ACKD) ? dly_cnt + 2'd1 : 2'd0;
            if (state == IDLE && nxt == REQ) begin
                ctl_addr  <= {1'b0, sdram_adr};
                ctl_wdata <= sdram_out;
                ctl_be    <= sdram_sel;
                wr_q      <= sdram_we;
                dm_h      <= sdram_we & ~sdram_sel[1];
                dm_l      <= sdram_we & ~sdram_sel[0];
            end
            if (state == REQ && !wr_q && ctl_rd_ack)
                sdram_dat <= ctl_rdata;
        end
    end
    assign ctl_wr_req = (state == REQ) & wr_q;
    assign ctl_rd_req = (state == REQ) & ~wr_q;
    assign sdram_ack  = (state == DONE) & sdram_stb;
endmodule

// File: tb/tb_sdram_wb_bridge.sv
// tb_sdram_wb_bridge: randomized and directed transactions against a cycle-level
// expectation of the bus/controller handshake, masks, latches and reset delay.
module tb_sdram_wb_bridge;
    localparam int ACK_DLY = 2;
    localparam int RST_DLY = 3;
    logic        clk_p = 1'b0;
    logic        rst_n = 1'b1;
    logic        sys_reset = 1'b0;
    logic        sdram_stb = 1'b0;
    logic        sdram_we = 1'b0;
    logic [1:0]  sdram_sel = 2'b00;
    logic [21:1] sdram_adr = '0;
    logic [15:0] sdram_out = '0;
    logic [15:0] sdram_dat;
    logic        sdram_ack, sdram_ready, ctl_rst_n, ctl_wr_req, ctl_rd_req;
    logic        ctl_wr_ack = 1'b0;
    logic        ctl_rd_ack = 1'b0;
    logic [21:0] ctl_addr;
    logic [15:0] ctl_wdata;
    logic [15:0] ctl_rdata = '0;
    logic [1:0]  ctl_be;
    logic        ctl_init_done = 1'b1;
    logic        dm_l, dm_h;
    logic [15:0] exp_dat = '0;
    int passed = 0;
    int total = 0;

    sdram_wb_bridge #(.ACK_DLY(ACK_DLY), .RST_DLY(RST_DLY)) dut (
        .clk_p(clk_p), .rst_n(rst_n), .sys_reset(sys_reset),
        .sdram_stb(sdram_stb), .sdram_we(sdram_we), .sdram_sel(sdram_sel),
        .sdram_adr(sdram_adr), .sdram_out(sdram_out), .sdram_dat(sdram_dat),
        .sdram_ack(sdram_ack), .sdram_ready(sdram_ready), .ctl_rst_n(ctl_rst_n),
        .ctl_wr_req(ctl_wr_req), .ctl_rd_req(ctl_rd_req), .ctl_wr_ack(ctl_wr_ack),
        .ctl_rd_ack(ctl_rd_ack), .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata),
        .ctl_rdata(ctl_rdata), .ctl_be(ctl_be), .ctl_init_done(ctl_init_done),
        .dm_l(dm_l), .dm_h(dm_h)
    );

    always #5 clk_p = ~clk_p;

    task automatic tick;
        @(posedge clk_p);
        #1;
    endtask

    // One bus transaction: request must appear the cycle after the strobe, last
    // exactly lat cycles, and the bus ack must follow ACK_DLY cycles after the controller ack.
    task automatic run_txn(input bit we, input logic [1:0] sel, input logic [20:0] adr,
                           input logic [15:0] wd, input int lat, input logic [15:0] rd, input bit abort);
        logic [21:0] exp_addr;
        exp_addr = {1'b0, adr};
        sdram_stb = 1'b1; sdram_we = we; sdram_sel = sel; sdram_adr = adr; sdram_out = wd;
        for (int i = 1; i <= lat; i++) begin
            tick();
            total++; if ({ctl_wr_req, ctl_rd_req} !== {we, !we}) $display("FAIL req_level cyc%0d: got %b%b want %b%b", i, ctl_wr_req, ctl_rd_req, we, !we); else passed++;
            total++; if ({ctl_addr, ctl_wdata, ctl_be} !== {exp_addr, wd, sel}) $display("FAIL latch: got %h/%h/%b want %h/%h/%b", ctl_addr, ctl_wdata, ctl_be, exp_addr, wd, sel); else passed++;
            total++; if ({dm_h, dm_l} !== {we & ~sel[1], we & ~sel[0]}) $display("FAIL mask: got %b%b want %b%b", dm_h, dm_l, we & ~sel[1], we & ~sel[0]); else passed++;
            total++; if (sdram_ack !== 1'b0) $display("FAIL ack_in_req: got %b want 0", sdram_ack); else passed++;
            if (i == 1) begin
                sdram_adr = 21'($urandom); sdram_out = 16'($urandom); sdram_sel = 2'($urandom);
            end
            if (abort) sdram_stb = 1'b0;
            ctl_wr_ack = we ? (i == lat) : 1'($urandom);
            ctl_rd_ack = !we ? (i == lat) : 1'($urandom);
            ctl_rdata  = (!we && i == lat) ? rd : 16'($urandom);
        end
        tick();
        ctl_wr_ack = 1'b0; ctl_rd_ack = 1'b0;
        if (!we) exp_dat = rd;
        total++; if ({ctl_wr_req, ctl_rd_req} !== 2'b00) $display("FAIL req_drop: got %b%b want 00", ctl_wr_req, ctl_rd_req); else passed++;
        for (int d = 1; d < ACK_DLY; d++) begin
            total++; if (sdram_ack !== 1'b0) $display("FAIL ack_early d%0d: got %b want 0", d, sdram_ack); else passed++;
            tick();
        end
        total++; if (sdram_ack !== !abort) $display("FAIL bus_ack: got %b want %b", sdram_ack, !abort); else passed++;
        total++; if (sdram_dat !== exp_dat) $display("FAIL rdata: got %h want %h", sdram_dat, exp_dat); else passed++;
        if (!abort)
            repeat ($urandom_range(0, 2)) begin
                tick();
                total++; if ({sdram_ack, ctl_wr_req, ctl_rd_req} !== 3'b100) $display("FAIL done_hold: got %b want 100", {sdram_ack, ctl_wr_req, ctl_rd_req}); else passed++;
            end
        sdram_stb = 1'b0;
        tick();
        total++; if ({sdram_ack, ctl_wr_req, ctl_rd_req} !== 3'b000) $display("FAIL release: got %b want 000", {sdram_ack, ctl_wr_req, ctl_rd_req}); else passed++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) tick();
        total++; if ({ctl_rst_n, ctl_wr_req, ctl_rd_req, sdram_ack, sdram_ready, dm_l, dm_h} !== 7'b0) $display("FAIL reset_ctl: got %b want 0", {ctl_rst_n, ctl_wr_req, ctl_rd_req, sdram_ack, sdram_ready, dm_l, dm_h}); else passed++;
        total++; if ({sdram_dat, ctl_addr, ctl_wdata, ctl_be} !== '0) $display("FAIL reset_data: got %h/%h/%h/%b want 0", sdram_dat, ctl_addr, ctl_wdata, ctl_be); else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_reset_release;
        int n;
        sys_reset = 1'b1;
        repeat (5) tick();
        total++; if ({ctl_rst_n, sdram_ready} !== 2'b00) $display("FAIL rst_hold: got %b want 00", {ctl_rst_n, sdram_ready}); else passed++;
        sys_reset = 1'b0;
        n = 0;
        for (int k = 1; k <= 20 && n == 0; k++) begin
            tick();
            if (ctl_rst_n === 1'b1) n = k;
        end
        total++; if (n !== 2 + RST_DLY) $display("FAIL rst_delay: got %0d want %0d", n, 2 + RST_DLY); else passed++;
        ctl_init_done = 1'b0; #1;
        total++; if (sdram_ready !== 1'b0) $display("FAIL ready_low: got %b want 0", sdram_ready); else passed++;
        ctl_init_done = 1'b1; #1;
        total++; if (sdram_ready !== 1'b1) $display("FAIL ready_high: got %b want 1", sdram_ready); else passed++;
    endtask

    task automatic test_word_write;
        run_txn(1'b1, 2'b11, 21'h12345, 16'hBEEF, 3, 16'h0, 1'b0);
    endtask

    task automatic test_byte_write;
        run_txn(1'b1, 2'b10, 21'($urandom), 16'($urandom), 2, 16'h0, 1'b0);
        run_txn(1'b0, 2'b01, 21'($urandom), 16'($urandom), 2, 16'h1234, 1'b0);
    endtask

    task automatic test_read;
        run_txn(1'b0, 2'b11, 21'h1FFFFF, 16'h0, 1, 16'hA5C3, 1'b0);
        run_txn(1'b1, 2'b11, 21'h000001, 16'h5555, 1, 16'h0, 1'b0);
    endtask

    task automatic test_abort;
        run_txn(1'b1, 2'b01, 21'($urandom), 16'($urandom), 4, 16'h0, 1'b1);
        run_txn(1'b0, 2'b11, 21'($urandom), 16'($urandom), 3, 16'($urandom), 1'b1);
        run_txn(1'b1, 2'b11, 21'($urandom), 16'($urandom), 1, 16'h0, 1'b0);
    endtask

    task automatic test_not_ready;
        ctl_init_done = 1'b0;
        sdram_stb = 1'b1; sdram_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if ({sdram_ack, ctl_wr_req, ctl_rd_req} !== 3'b000) $display("FAIL not_ready: got %b want 000", {sdram_ack, ctl_wr_req, ctl_rd_req}); else passed++;
        end
        sdram_stb = 1'b0; ctl_init_done = 1'b1;
        tick();
    endtask

    task automatic test_mid_reset;
        int n;
        sdram_stb = 1'b1; sdram_we = 1'b0; sdram_sel = 2'b11;
        tick();
        total++; if (ctl_rd_req !== 1'b1) $display("FAIL mid_req: got %b want 1", ctl_rd_req); else passed++;
        sys_reset = 1'b1;
        repeat (3) tick();
        total++; if ({ctl_wr_req, ctl_rd_req, sdram_ack, ctl_rst_n} !== 4'b0) $display("FAIL mid_drop: got %b want 0000", {ctl_wr_req, ctl_rd_req, sdram_ack, ctl_rst_n}); else passed++;
        sdram_stb = 1'b0; sys_reset = 1'b0;
        n = 0;
        for (int k = 1; k <= 20 && n == 0; k++) begin
            tick();
            if (ctl_rst_n === 1'b1) n = k;
        end
        total++; if (n !== 2 + RST_DLY) $display("FAIL mid_recover: got %0d want %0d", n, 2 + RST_DLY); else passed++;
        run_txn(1'b0, 2'b11, 21'($urandom), 16'h0, 2, 16'($urandom), 1'b0);
    endtask

    task automatic test_back_to_back;
        for (int t = 0; t < 24; t++)
            run_txn(1'($urandom), 2'($urandom), 21'($urandom), 16'($urandom),
                    $urandom_range(1, 4), 16'($urandom), $urandom_range(0, 7) == 0);
    endtask

    initial begin
        test_reset();
        test_reset_release();
        test_word_write();
        test_byte_write();
        test_read();
        test_abort();
        test_not_ready();
        test_mid_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/sdram_wb_bridge.md
# sdram_wb_bridge

Bus-side adapter between the kernel's 16-bit SDRAM port (`sdram_stb`/`sdram_we`/`sdram_sel`/`sdram_ack`) and the request/acknowledge SDRAM controller on Tang Primer class boards. It does four things:
- generates the delayed controller reset;
- latches address, write data and byte lanes for each transaction;
- drives the per-byte data-mask pins of the SDRAM PHY;
- returns a registered two-cycle-delayed acknowledge to the kernel.

It replaces the free-standing glue logic in the board top with a single clocked state machine.

## Interface
Parameters:
- `ACK_DLY`, 2: cycles from controller ack to bus ack (legal 1..3).
- `RST_DLY`, 3: cycles controller reset is held after `sys_reset` is released.

Ports:
- `clk_p`  in  1  processor clock, direct phase; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sys_reset`  in  1  kernel SDRAM reset request, active-high, asynchronous to `clk_p`.
- `sdram_stb`  in  1  bus transaction strobe.
- `sdram_we`  in  1  1 = write, 0 = read.
- `sdram_sel`  in  2  byte select, [1] high byte, [0] low byte.
- `sdram_adr`  in  21  word address [21:1].
- `sdram_out`  in  16  write data from kernel.
- `sdram_dat`  out  16  read data to kernel.
- `sdram_ack`  out  1  transaction acknowledge.
- `sdram_ready`  out  1  controller initialised, passed to the kernel.
- `ctl_rst_n`  out  1  controller reset, active-low.
- `ctl_wr_req`  out  1  write request.
- `ctl_rd_req`  out  1  read request.
- `ctl_wr_ack`  in  1  write accepted.
- `ctl_rd_ack`  in  1  read data valid.
- `ctl_addr`  out  22  `{1'b0, adr}`, drives both wraddr and rdaddr.
- `ctl_wdata`  out  16  latched write data.
- `ctl_rdata`  in  16  controller read data.
- `ctl_be`  out  2  latched `sdram_sel`.
- `ctl_init_done`  in  1  controller initialisation complete.
- `dm_l`, `dm_h`  out  1 each  PHY data masks, 1 = byte masked.

## Operation
**Reset generator**
- `sys_reset` passes through a two-flop synchroniser.
- While the synchronised value is 1, `ctl_rst_n` is 0 and the delay counter is cleared.
- After release, the counter runs `RST_DLY` cycles, then `ctl_rst_n` goes to 1.
- `sdram_ready` = `ctl_init_done & ctl_rst_n`.

**FSM states**
- IDLE:
  - If `sdram_stb & sdram_ready`, latch the following, then go to REQ:
    - `sdram_adr` into `ctl_addr`;
    - `sdram_out` into `ctl_wdata`;
    - `sdram_sel` into `ctl_be`;
    - `sdram_we` into `wr_q`.
  - Mask latch in the same cycle: for a write, `dm_h` = ~sel[1] and `dm_l` = ~sel[0]; for a read, both are 0.
- REQ:
  - `ctl_wr_req` = `wr_q`, `ctl_rd_req` = ~`wr_q`.
  - On the matching ack, go to ACKD.
  - On a read, `ctl_rdata` is captured into `sdram_dat` on the `ctl_rd_ack` cycle.
- ACKD: wait `ACK_DLY`-1 cycles, then go to DONE.
- DONE:
  - `sdram_ack` = `sdram_stb`.
  - When `sdram_stb` is 0, return to IDLE.

**Other rules**
- Requests are registered outputs decoded from state. They are never combinational from `sdram_stb`.
- Strobe dropped during REQ: the request is held until the controller acks, the transaction completes internally, and the FSM goes to IDLE from DONE without asserting `sdram_ack`.
- Strobe while not ready: ignored; the FSM stays in IDLE and no ack is given.
- Ack on the non-matching line (e.g. `ctl_rd_ack` during a write) is ignored.
- `sdram_dat` holds its last read value through writes.
- Synchronised `sys_reset` = 1 mid-transaction: FSM forced to IDLE, requests dropped, no ack.

## Timing
- Reset values:
  - all zero: `ctl_rst_n`, `ctl_wr_req`, `ctl_rd_req`, `sdram_ack`, `sdram_ready`, `sdram_dat`, `ctl_addr`, `ctl_wdata`, `ctl_be`, `dm_l`, `dm_h`;
  - synchroniser and counter cleared;
  - FSM in IDLE.
- Cycle T: `sdram_stb` sampled in IDLE. Request is high from T+1.
- Controller ack sampled at cycle K: request low from K+1, `sdram_ack` high from K+`ACK_DLY`.
- Minimum transaction: ack in the same cycle the request is first seen. Bus ack then arrives at T+1+`ACK_DLY`.
- Back-to-back: the next strobe is accepted the first cycle IDLE is re-entered. A strobe that stays high through DONE is one transaction, not two.
- `ctl_rst_n` rises `2+RST_DLY` cycles after `sys_reset` falls.
- `dm_l`/`dm_h` are stable from T+1 until the next IDLE acceptance.

## Test plan
- **Reset release:** pulse `sys_reset` high 5 cycles then low. `ctl_rst_n` rises exactly 5 cycles after the fall. `sdram_ready` follows `ctl_init_done`.
- **Word write:** adr=0x12345, data=0xBEEF, sel=2'b11, controller acks 3 cycles after the request. Expect `ctl_addr`=0x012345, `ctl_wr_req` for 3 cycles, `dm_l`=`dm_h`=0, and `sdram_ack` 2 cycles after the controller ack.
- **Byte write:** sel=2'b10. Expect `dm_h`=0 and `dm_l`=1 for the transaction. A subsequent read shows both masks at 0.
- **Read:** controller returns 0xA5C3 with `ctl_rd_ack`. Expect `sdram_dat`=0xA5C3 when `sdram_ack` rises, held through a following write.
- **Aborted strobe:** drop `sdram_stb` one cycle after acceptance. The request is held until the controller ack, `sdram_ack` stays 0, and the FSM reaches IDLE.
- **Not ready / mid-reset:** strobe with `ctl_init_done`=0 gives no request. Asserting `sys_reset` during REQ drops the request within 3 cycles and returns the FSM to IDLE.
